// File: rtl/mem_ctrl_pkg.sv
// Shared constants and helpers for the byte-wide RAM port controller.
package mem_ctrl_pkg;

  localparam logic [2:0] MemIdle  = 3'd0;
  localparam logic [2:0] MemIfRd  = 3'd1;
  localparam logic [2:0] MemMemRd = 3'd2;
  localparam logic [2:0] MemMemWr = 3'd3;
  localparam logic [2:0] MemDone  = 3'd4;

  localparam logic [1:0] LenByte = 2'b00;
  localparam logic [1:0] LenHalf = 2'b01;
  localparam logic [1:0] LenWord = 2'b10;

  localparam logic RamWrite = 1'b1;
  localparam logic RamRead  = 1'b0;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  typedef enum logic {
    SrcIf  = 1'b0,
    SrcMem = 1'b1
  } req_src_e;

  // Everything about the accepted request except its address.
  typedef struct packed {
    req_src_e    src;
    logic        we;
    logic [2:0]  nbytes;
    logic [31:0] wdata;
  } req_info_t;

  function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
    case (len)
      LenByte:        return 3'd1;
      LenHalf:        return 3'd2;
      LenWord, 2'b11: return 3'd4;
      default:        return 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Request/response and RAM bus bundle for mem_ctrl.
interface mem_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);

  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic [31:0]           if_data;
  logic                  if_done;

  logic                  mem_req;
  logic                  mem_we;
  logic [1:0]            mem_len;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;
  logic                  mem_done;

  logic [7:0]            ram_din;
  logic [7:0]            ram_dout;
  logic [ADDR_WIDTH-1:0] ram_a;
  logic                  ram_wr;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
    output if_data, if_done, mem_rdata, mem_done, ram_dout, ram_a, ram_wr
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
    input  if_data, if_done, mem_rdata, mem_done, ram_dout, ram_a, ram_wr
  );

endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates IF and MEM onto one byte-wide RAM port (MEM first), splits accesses
// into byte transactions and returns little-endian read data with a done pulse.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rdy_in,
  input  logic       branch_flag_in,
  mem_ctrl_if.slave  bus
);

  logic [2:0]            state;
  logic [2:0]            cnt;
  logic [2:0]            cnt_inc;
  req_info_t             req;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [ADDR_WIDTH-1:0] ram_a_q;
  logic [7:0]            ram_dout_q;
  logic                  ram_wr_q;
  logic [31:0]           rbuf;
  logic [31:0]           next_buf;
  logic [31:0]           if_data_q;
  logic [31:0]           mem_rdata_q;
  logic                  if_done_q;
  logic                  mem_done_q;

  assign cnt_inc   = cnt + 3'd1;
  assign next_addr = base_addr + ADDR_WIDTH'(cnt_inc);

  // The byte on ram_din belongs to the address issued one cycle earlier (index cnt-1).
  always_comb begin
    next_buf = rbuf;
    case (cnt)
      3'd1:    next_buf[7:0]   = bus.ram_din;
      3'd2:    next_buf[15:8]  = bus.ram_din;
      3'd3:    next_buf[23:16] = bus.ram_din;
      3'd4:    next_buf[31:24] = bus.ram_din;
      default: next_buf        = rbuf;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state       <= MemIdle;
      cnt         <= 3'd0;
      req         <= '0;
      base_addr   <= '0;
      ram_a_q     <= '0;
      ram_dout_q  <= 8'h00;
      ram_wr_q    <= RamRead;
      rbuf        <= ZeroWord;
      if_data_q   <= ZeroWord;
      mem_rdata_q <= ZeroWord;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
    end else if (rdy_in) begin
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      case (state)
        MemIdle: begin
          cnt      <= 3'd0;
          ram_a_q  <= '0;
          ram_wr_q <= RamRead;
          if (bus.mem_req) begin
            req       <= '{src: SrcMem, we: bus.mem_we,
                           nbytes: len_to_bytes(bus.mem_len), wdata: bus.mem_wdata};
            base_addr <= bus.mem_addr;
            ram_a_q   <= bus.mem_addr;
            rbuf      <= ZeroWord;
            if (bus.mem_we) begin
              state      <= MemMemWr;
              ram_wr_q   <= RamWrite;
              ram_dout_q <= bus.mem_wdata[7:0];
            end else begin
              state <= MemMemRd;
            end
          end else if (bus.if_req && !branch_flag_in) begin
            req       <= '{src: SrcIf, we: 1'b0, nbytes: 3'd4, wdata: ZeroWord};
            base_addr <= bus.if_addr;
            ram_a_q   <= bus.if_addr;
            rbuf      <= ZeroWord;
            state     <= MemIfRd;
          end
        end

        // Read states run n+1 cycles: n address cycles overlapped with n capture cycles.
        MemIfRd, MemMemRd: begin
          if (state == MemIfRd && branch_flag_in) begin
            state   <= MemIdle;
            cnt     <= 3'd0;
            ram_a_q <= '0;
          end else begin
            if (cnt != 3'd0) begin
              rbuf <= next_buf;
            end
            if (cnt == req.nbytes) begin
              state   <= MemDone;
              cnt     <= 3'd0;
              ram_a_q <= '0;
              if (req.src == SrcIf) begin
                if_data_q <= next_buf;
                if_done_q <= 1'b1;
              end else begin
                mem_rdata_q <= next_buf;
                mem_done_q  <= 1'b1;
              end
            end else begin
              cnt     <= cnt_inc;
              ram_a_q <= (cnt_inc < req.nbytes) ? next_addr : '0;
            end
          end
        end

        MemMemWr: begin
          if (cnt_inc == req.nbytes) begin
            state      <= MemDone;
            cnt        <= 3'd0;
            ram_a_q    <= '0;
            ram_dout_q <= 8'h00;
            ram_wr_q   <= RamRead;
            mem_done_q <= 1'b1;
          end else begin
            cnt        <= cnt_inc;
            ram_a_q    <= next_addr;
            ram_dout_q <= byte_of(req.wdata, cnt_inc[1:0]);
          end
        end

        MemDone: begin
          state <= MemIdle;
        end

        default: begin
          state    <= MemIdle;
          cnt      <= 3'd0;
          ram_a_q  <= '0;
          ram_wr_q <= RamRead;
        end
      endcase
    end
  end

  // A frozen pipeline must never repeat a write, so the strobe is gated live.
  assign bus.ram_wr    = ram_wr_q & rdy_in;
  assign bus.ram_a     = ram_a_q;
  assign bus.ram_dout  = ram_dout_q;
  assign bus.if_data   = if_data_q;
  assign bus.if_done   = if_done_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.mem_done  = mem_done_q;

endmodule
